// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed big-endian program into instruction memory while holding the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the last word.
module imem_loader #(
  parameter int unsigned DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK, DONE, ERR} state_t;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t FIN = CHK;
  logic [7:0] chk;
`else
  localparam state_t FIN = DONE;
`endif
  state_t state, next;
  logic [7:0]  len_hi;
  logic [15:0] len, idx, n;
  logic [1:0]  bidx;
  logic [23:0] word;
  logic        xfer, restart;
  assign n       = {len_hi, byte_data};
  assign xfer    = byte_valid & byte_ready;
  assign restart = start & (state == IDLE || state == DONE || state == ERR);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next       = state;
    byte_ready = state == LEN_HI || state == LEN_LO || state == DATA || state == CHK;
    wr_en      = state == WRITE;
    done       = state == DONE;
    error      = state == ERR;
    cpu_hold   = state != DONE;
    case (state)
      IDLE, DONE, ERR: next = start ? LEN_HI : state;
      LEN_HI: next = xfer ? LEN_LO : state;
      LEN_LO: next = !xfer ? state : ({16'd0, n} > DEPTH) ? ERR : (n == '0) ? FIN : DATA;
      DATA:   next = (xfer && bidx == 2'd3) ? WRITE : state;
      WRITE:  next = ({16'd0, idx} + 32'd1 < {16'd0, len}) ? DATA : FIN;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:    next = !xfer ? state : (byte_data == chk) ? DONE : ERR;
`endif
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      len_hi  <= '0;
      len     <= '0;
      idx     <= '0;
      bidx    <= '0;
      word    <= '0;
      wr_addr <= '0;
      wr_data <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk     <= '0;
`endif
    end else begin
      if (restart) begin
        idx  <= '0;
        bidx <= '0;
        word <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk  <= '0;
`endif
      end
      if (xfer && state == LEN_HI) len_hi <= byte_data;
      if (xfer && state == LEN_LO) len <= n;
      if (xfer && state == DATA) begin
        bidx <= bidx + 2'd1;
        word <= {word[15:0], byte_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk  <= chk ^ byte_data;
`endif
        // address/data latch on the final byte so they are valid throughout WRITE and hold afterwards
        if (bidx == 2'd3) begin
          wr_data <= {word, byte_data};
          wr_addr <= {14'd0, idx, 2'b00};
        end
      end
      if (state == WRITE) idx <= idx + 16'd1;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning instruction memory size in 32-bit words.
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  begins a load session when sampled high in IDLE, DONE or ERR.
REQ-005 SHALL have port byte_valid  input  1  a byte is offered on byte_data.
REQ-006 SHALL have port byte_data  input  8  incoming program stream byte.
REQ-007 SHALL have port byte_ready  output  1  loader accepts byte this cycle.
REQ-008 SHALL have port wr_en  output  1  one-cycle instruction memory write strobe.
REQ-009 SHALL have port wr_addr  output  32  byte address of write, always a multiple of 4, same addressing as pc.
REQ-010 SHALL have port wr_data  output  32  instruction word to write.
REQ-011 SHALL have port cpu_hold  output  1  keeps the CPU stalled while high.
REQ-012 SHALL have port done  output  1  load completed successfully.
REQ-013 SHALL have port error  output  1  load aborted.

Function
REQ-014 SHALL transfer a byte only on a rising edge where byte_valid and byte_ready are both high.
REQ-015 SHALL use states IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK, DONE, ERR.
REQ-016 SHALL move from IDLE/DONE/ERR to LEN_HI on start, clearing done, error, word index and byte index, and setting cpu_hold.
REQ-017 SHALL read a 16-bit big-endian word count N: LEN_HI takes the high byte, LEN_LO the low byte.
REQ-018 SHALL, after LEN_LO, go to ERR if N > DEPTH; go to DONE (or CHK when checksum is enabled) if N = 0; otherwise go to DATA.
REQ-019 SHALL assemble each word in DATA from 4 bytes, most-significant byte first.
REQ-020 SHALL, after the 4th byte, enter WRITE for exactly one cycle with wr_en=1, wr_addr=index*4 and wr_data=the assembled word, with byte_ready=0.
REQ-021 SHALL leave WRITE for DATA if index+1 < N, else for DONE (or CHK), incrementing index.
REQ-022 SHALL hold byte_ready=1 in LEN_HI, LEN_LO, DATA and CHK, and 0 in all other states.
REQ-023 SHALL, in DONE, hold done=1 and cpu_hold=0.
REQ-024 SHALL, in ERR, hold error=1 and cpu_hold=1, and ignore incoming bytes.
REQ-025 SHALL ignore start in LEN_HI, LEN_LO, DATA, WRITE and CHK.
REQ-026 SHALL drive wr_en=0 in every state except WRITE.
REQ-027 SHALL keep wr_addr and wr_data stable while wr_en=0 (they hold their last value).

Reset
REQ-028 SHALL, on rst low and regardless of clk, enter IDLE with byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0, and the assembled word and indices cleared.
REQ-029 SHALL, on reset in mid-session, discard the partial word and issue no further write.

Configuration
REQ-030 SHALL, with IMEM_LOADER_CHECKSUM_EN defined, enter CHK after the last word, take one byte, and go to DONE if it equals the XOR of all data bytes (0x00 when N=0), else go to ERR.
REQ-031 SHALL, without IMEM_LOADER_CHECKSUM_EN, omit CHK entirely and expect no checksum byte.

Verification
REQ-032 SHALL cover a basic load: start; stream 00 02 20 10 00 08 20 11 00 0E -> writes (0x0, 0x20100008) then (0x4, 0x2011000E); done=1, cpu_hold=0.
REQ-033 SHALL cover a zero-length load: N = 00 00 -> no wr_en pulse; done=1 (after checksum byte 00 when enabled).
REQ-034 SHALL cover an oversize load with DEPTH=64: N = 00 41 -> error=1, cpu_hold=1, no writes; a following start restarts cleanly.
REQ-035 SHALL cover backpressure: byte_valid toggling every cycle, plus a byte offered during WRITE -> that byte is not consumed and the word assembles correctly.
REQ-036 SHALL cover reset mid-session: rst low after 2 of 4 data bytes -> IDLE, all outputs at reset values, no write.
REQ-037 SHALL cover the checksum option (IMEM_LOADER_CHECKSUM_EN): N=1, word 12 34 56 78, checksum byte 08 -> DONE; checksum byte 09 -> ERR.
